// File: rtl/twiddle_sched_pkg.sv
// rtl/twiddle_sched_pkg.sv - shared FSM states, frame constants and twiddle tag type
package twiddle_sched_pkg;

  localparam int N_LOG2_DEF = 5;
  localparam int N_STAGES   = N_LOG2_DEF;
  localparam int N_BFLY     = 2 ** (N_LOG2_DEF - 1);
  localparam int ROM_LAT    = 2;
  localparam int TAG_BFLY_W = N_LOG2_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [2:0]            stage;
    logic [TAG_BFLY_W-1:0] bfly;
    logic                  last;
  } tw_tag_t;

endpackage

// File: rtl/twiddle_sched_tag_pipe.sv
// rtl/twiddle_sched_tag_pipe.sv - tw_tag_pipe: DEPTH-stage tag delay line matching ROM read latency
module tw_tag_pipe
  import twiddle_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  tw_tag_t tag_i,
  output tw_tag_t tag_o
);

  tw_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/twiddle_sched.sv
// rtl/twiddle_sched.sv - twiddle ROM address sequencer for a radix-2 FFT frame
// TWIDDLE_SCHED_DIT_EN selects decimation-in-time index ordering (default DIF).
module twiddle_sched #(
  parameter int N_LOG2  = 5,
  parameter int ADDR_W  = 4,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              tw_valid,
  output logic [2:0]        tw_stage,
  output logic [ADDR_W-1:0] tw_bfly,
  output logic              tw_last
);

  import twiddle_sched_pkg::*;

  localparam int NB = 2 ** (N_LOG2 - 1);
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_e            state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [ADDR_W-1:0] bfly_q, bfly_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic              issue;
  logic              is_last;
  logic [ADDR_W-1:0] k_idx;
  tw_tag_t           tag_in, tag_out;

  assign is_last = (stage_q == 3'(N_LOG2 - 1)) && (bfly_q == ADDR_W'(NB - 1));

  always_comb begin
    k_idx = '0;
`ifdef TWIDDLE_SCHED_DIT_EN
    k_idx = ADDR_W'((32'(bfly_q) & ((32'd1 << stage_q) - 32'd1))
                    << (32'(N_LOG2 - 1) - 32'(stage_q)));
`else
    k_idx = ADDR_W'((32'(bfly_q) & ((32'd1 << (32'(N_LOG2 - 1) - 32'(stage_q))) - 32'd1))
                    << stage_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      ST_RUN: begin
        if (!pause) begin
          issue = 1'b1;
          if (is_last) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else if (bfly_q == ADDR_W'(NB - 1)) begin
            bfly_d  = '0;
            stage_d = stage_q + 3'd1;
          end else begin
            bfly_d = bfly_q + 1'b1;
          end
        end
      end
      // Hold until the last issued word has left the ROM output register.
      ST_DRAIN: begin
        if (drain_q == CW'(ROM_LAT - 1)) state_d = ST_DONE;
        else                             drain_d = drain_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.stage = issue ? stage_q : 3'd0;
    tag_in.bfly  = issue ? TAG_BFLY_W'(bfly_q) : '0;
    tag_in.last  = issue & is_last;
  end

  tw_tag_pipe #(
    .DEPTH (ROM_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rom_en   = issue;
  assign rom_addr = issue ? k_idx : '0;
  assign tw_valid = tag_out.valid;
  assign tw_stage = tag_out.stage;
  assign tw_bfly  = ADDR_W'(tag_out.bfly);
  assign tw_last  = tag_out.last;

endmodule

// File: tb/tb_twiddle_sched.sv
// tb/tb_twiddle_sched.sv - randomized self-checking bench for twiddle_sched against a frame-level model
module tb_twiddle_sched;

  localparam int NL   = 5;
  localparam int NB   = 2 ** (NL - 1);
  localparam int NTOT = NL * NB;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic       busy, done, rom_en, tw_valid, tw_last;
  logic [3:0] rom_addr, tw_bfly;
  logic [2:0] tw_stage;

  always #5 clk = ~clk;

  twiddle_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .tw_valid (tw_valid),
    .tw_stage (tw_stage),
    .tw_bfly  (tw_bfly),
    .tw_last  (tw_last)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Twiddle index straight from the stage/butterfly rule.
  function automatic int exp_k(input int s, input int b);
`ifdef TWIDDLE_SCHED_DIT_EN
    return ((b % (2 ** s)) * (2 ** (NL - 1 - s))) % NB;
`else
    return ((b % (2 ** (NL - 1 - s))) * (2 ** s)) % NB;
`endif
  endfunction

  typedef struct {
    int t;
    int idx;
  } pend_t;

  bit    m_ok   = 1'b0;
  bit    m_busy = 1'b0;
  bit    m_run  = 1'b0;
  int    issued = 0;
  int    done_at = -1;
  bit    exp_en, exp_v;
  pend_t e;
  pend_t pend[$];
  int    done_q[$];
  int    last_q[$];

  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", busy, m_busy);
      check("done", done, cyc == done_at);
      exp_en = m_run && !pause;
      check("rom_en", rom_en, exp_en);
      if (exp_en) begin
        check("rom_addr", rom_addr, exp_k(issued / NB, issued % NB));
        pend.push_back('{cyc + 2, issued});
        if (issued == NTOT - 1) begin
          done_at = cyc + 3;
          m_run   = 1'b0;
        end
        issued++;
      end
      exp_v = (pend.size() > 0) && (pend[0].t == cyc);
      check("tw_valid", tw_valid, exp_v);
      if (exp_v) begin
        e = pend.pop_front();
        check("tw_stage", tw_stage, e.idx / NB);
        check("tw_bfly", tw_bfly, e.idx % NB);
        check("tw_last", tw_last, e.idx == NTOT - 1);
      end
      if (done) done_q.push_back(cyc);
      if (tw_valid && tw_last) last_q.push_back(cyc);
      if (rst) begin
        m_busy = 1'b0;
        m_run  = 1'b0;
        pend.delete();
        done_at = -1;
      end else if (cyc == done_at) begin
        m_busy = 1'b0;
      end else if (!m_busy && start) begin
        m_busy = 1'b1;
        m_run  = 1'b1;
        issued = 0;
      end
    end else if (rst) begin
      m_ok = 1'b1;
    end
  end

  task automatic pulse_start(output int n);
    start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int k);
    int lim;
    lim = cyc + 400;
    while (done_q.size() < k && cyc < lim) begin
      @(posedge clk); #1;
    end
    if (done_q.size() < k) check("done_timeout", done_q.size(), k);
  endtask

  function automatic int done_rel(input int k, input int n);
    return (done_q.size() > k) ? done_q[k] - n : -1;
  endfunction

  int n, n2, pv, pe, nd, lim;

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // plain frame
    pulse_start(n);
    wait_done(1);
    check("lat_plain", done_rel(0, n), 83);
    check("last_plain", (last_q.size() > 0) ? last_q[0] - n : -1, 82);

    // pause for 5 cycles right after stage 2, butterfly 6
    pulse_start(n);
    wait_cyc(n + 40);
    pause = 1'b1;
    pv = 0; pe = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pv += int'(tw_valid);
      pe += int'(rom_en);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    wait_done(2);
    check("pause_valid", pv, 2);
    check("pause_en", pe, 0);
    check("lat_pause", done_rel(1, n), 88);

    // start while busy is ignored
    pulse_start(n);
    wait_cyc(n + 40);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3);
    check("lat_busy_start", done_rel(2, n), 83);

    // mid-frame reset, then a fresh frame
    pulse_start(n);
    wait_cyc(n + 30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", int'({busy, done, rom_en, tw_valid, tw_last, tw_stage, tw_bfly, rom_addr}), 0);
    @(posedge clk); #1;
    wait_cyc(n + 35);
    pulse_start(n2);
    wait_done(4);
    check("lat_after_rst", done_rel(3, n2), 83);

    // back-to-back frames
    pulse_start(n);
    wait_done(5);
    wait_cyc(n + 84);
    pulse_start(n2);
    wait_done(6);
    check("b2b_first", done_rel(4, n), 83);
    check("b2b_second", done_rel(5, n), 167);

    // randomized pause and stray start traffic
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
      end
      nd = done_q.size();
      pulse_start(n);
      lim = cyc + 2000;
      while (m_busy && cyc < lim) begin
        pause = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 15) == 0);
        @(posedge clk); #1;
      end
      start = 1'b0;
      pause = 1'b0;
      check("rand_done", done_q.size(), nd + 1);
    end

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twiddle_sched.md
Name: twiddle_sched

Overview:
- Address sequencer for the 16-entry twiddle ROM, which has 2-cycle read latency (en/addr registered, then output registered).
- Walks every stage and butterfly of a 2^N_LOG2-point radix-2 FFT and issues the correct twiddle index per butterfly.
- Emits tw_valid/stage/butterfly tags aligned with the ROM's data_out so the PE array can pair each twiddle with its butterfly.
- Sits between the FFT frame controller (start/done) and the ROM + PE array.

Parameters:
- N_LOG2, 5: log2 FFT size. Stages = N_LOG2; butterflies per stage = 2^(N_LOG2-1).
- ADDR_W, 4: ROM address width. Must equal N_LOG2-1.
- ROM_LAT, 2: ROM read latency in cycles; tag pipeline depth.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request
- pause  in  1  freeze issue while high
- busy  out  1  high from frame accept until done
- done  out  1  one-cycle pulse after last twiddle delivered
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W  ROM twiddle index
- tw_valid  out  1  ROM data_out valid this cycle
- tw_stage  out  3  stage of current twiddle
- tw_bfly  out  ADDR_W  butterfly index of current twiddle
- tw_last  out  1  final twiddle of frame (with tw_valid)

Behaviour:
- Reset: every output 0; FSM to IDLE; counters and tag pipeline cleared. Reset mid-frame aborts with no done pulse; in-flight tags are dropped.
- States:
  - IDLE: start=1 goes to RUN next cycle and sets busy.
  - RUN: issues one butterfly per cycle while pause=0. After stage N_LOG2-1, butterfly 2^(N_LOG2-1)-1 is issued, goes to DRAIN.
  - DRAIN: waits ROM_LAT cycles for the pipeline to empty, then goes to DONE.
  - DONE: done=1 for one cycle, busy drops, returns to IDLE.
- start outside IDLE is ignored.
- Issue: in RUN with pause=0, rom_en=1 and rom_addr=k(s,b). Then b increments; on b wrap to 0, s increments. rom_en=0 in every other state and whenever pause=1.
- pause freezes s and b. Twiddles already issued (at most ROM_LAT) still emerge. Downstream must absorb 2 in-flight words.
- DIF index: k = (b mod 2^(N_LOG2-1-s)) << s, truncated to ADDR_W.
- Tag pipeline: {valid, s, b, last} delayed ROM_LAT cycles. tw_valid is asserted exactly when data_out holds twiddle k(s,b). tw_last = valid issue of last (s,b), delayed.
- Latency, start sampled at edge t, no pause:
  - issue cycles t+1 .. t+80
  - tw_valid cycles t+3 .. t+82
  - done in cycle t+83; busy low from t+84
  - next start accepted from t+84
- Simultaneous start and done: the start is ignored because the FSM is not in IDLE.

Optional Feature:
- Macro TWIDDLE_SCHED_DIT_EN.
- Defined: decimation-in-time ordering, k = (b mod 2^s) << (N_LOG2-1-s). Stage 0 uses only W0; the last stage uses W0..W15 in order.
- Undefined: DIF ordering as above.
- Counters, handshake and latency are identical either way.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN, DRAIN, DONE)
  - constants N_STAGES, N_BFLY, ROM_LAT
  - tag struct {valid, stage, bfly, last}
- One sub-module: tw_tag_pipe, a ROM_LAT-deep shift register of tags with synchronous clear.
- Index computation stays inline.

Test Plan:
- Reset then start at t=10, DIF:
  - rom_addr in stage 0 is 0,1,...,15
  - stage 1 is 0,2,...,14,0,2,...,14
  - stage 4 is all 0
  - tw_valid spans cycles 13..92, tw_last at 92, done at 93
- TWIDDLE_SCHED_DIT_EN build:
  - stage 0 all 0
  - stage 1 alternates 0,8
  - stage 4 is 0..15
  - done at t+83
- pause high for 5 cycles mid stage 2 (after b=6):
  - rom_en low for those cycles; b=7 resumes afterwards
  - exactly 2 extra tw_valid pulses appear during the pause
  - done delayed to t+88
- start pulsed while busy at t+40:
  - no effect; sequence and done timing unchanged
- rst asserted at t+30:
  - next cycle all outputs 0, no done pulse
  - a new start at t+35 produces a full, correct frame
- Back-to-back: start at t, then a second start in the cycle busy drops (t+84):
  - two complete frames, done pulses at t+83 and t+167
